sr8_seq: RTL and testbench



---
 rtl/sr_pkg.sv | 16 +
 rtl/sr_step.sv | 12 +
 rtl/sr8_seq.sv | 79 +++++++
 tb/tb_sr8_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the sequential right shifter: state encoding,
// default width and the shift-amount saturation helper.
package sr_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Clamp a shift amount to the data width; anything wider shifts everything out.
    function automatic logic [7:0] sat_amt(input logic [7:0] b, input int width);
        return (int'(b) >= width) ? 8'(width) : b;
    endfunction

endpackage

// File: rtl/sr_step.sv
// One-bit right-shift stage: drops the LSB and inserts the fill bit at the MSB.
module sr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    assign shifted = {fill, data[WIDTH-1:1]};

endmodule

// File: rtl/sr8_seq.sv
// Sequential right shifter, one bit per clock, start/ready in and valid/ready out.
// Define SR8_SRA_EN to enable arithmetic shifts via the arith input.
module sr8_seq
    import sr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [7:0]       b,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    logic [1:0]       state;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_sh;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] amt;
    logic             fill;
    logic             fill_in;

`ifdef SR8_SRA_EN
    assign fill_in = arith & a[WIDTH-1];
`else
    // Logical-only build: arith is part of the port list but has no effect.
    logic unused_arith;
    assign unused_arith = arith;
    assign fill_in      = 1'b0;
`endif

    assign amt = CNT_W'(sat_amt(b, WIDTH));

    sr_step #(.WIDTH(WIDTH)) u_step (
        .data    (data),
        .fill    (fill),
        .shifted (data_sh)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out       = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            data  <= '0;
            count <= '0;
            fill  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data  <= a;
                        count <= amt;
                        fill  <= fill_in;
                        state <= (amt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data  <= data_sh;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr8_seq.sv
// Self-checking bench for sr8_seq: directed cases plus randomized traffic
// checked every cycle against a transaction-level timeline model.
module tb_sr8_seq;

`ifdef SR8_SRA_EN
    localparam bit SRA = 1'b1;
`else
    localparam bit SRA = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       arith = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;

    int n_chk  = 0;
    int n_fail = 0;

    sr8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: treat operand as signed when doing SRA and use integer >>>.
    function automatic logic [7:0] ref_sr(input logic [7:0] av, input logic [7:0] bv, input logic ar);
        int k = (bv >= 8) ? 8 : int'(bv);
        int v = (SRA && ar && av[7]) ? int'(av) - 256 : int'(av);
        return 8'(v >>> k);
    endfunction

    // Timeline model: a request taken at edge E with amount k is valid from E+k
    // until the first edge where out_ready is seen while valid.
    longint cyc = 0;
    longint ready_at = 0;
    bit     m_busy = 1'b0;
    logic [7:0] m_res = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_res  = 8'd0;
        end else begin
            if (m_busy) begin
                if (cyc >= ready_at && out_ready) m_busy = 1'b0;
            end else if (in_valid) begin
                m_busy   = 1'b1;
                ready_at = cyc + 1 + ((b >= 8) ? 8 : longint'(b));
                m_res    = ref_sr(a, b, arith);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_busy && cyc >= ready_at});
            if (m_busy && cyc >= ready_at) chk("cyc_out", {24'd0, out}, {24'd0, m_res});
        end
    end

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ar,
                         input logic [7:0] ev, input int el, input int hold, input string nm);
        int lat;
        @(posedge clk); #1;
        a = av; b = bv; arith = ar; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        // While busy, keep presenting a different request that must be ignored.
        in_valid = (hold > 0); a = ~av; b = 8'd0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, el);
        chk({nm, "_out"}, {24'd0, out}, {24'd0, ev});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_out"}, {24'd0, out}, {24'd0, ev});
            chk({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);

        // Abort mid-shift with reset.
        @(posedge clk); #1;
        a = 8'hF0; b = 8'd5; arith = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out", {24'd0, out}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(8'h81, 8'd1, 1'b0, 8'h40, 1, 0, "post_reset");

        do_op(8'hB4, 8'd3, 1'b0, 8'h16, 3, 0, "logical");
        do_op(8'h5A, 8'd0, 1'b0, 8'h5A, 0, 0, "zero_amt");
        do_op(8'hFF, 8'h09, 1'b0, 8'h00, 8, 0, "sat_9");
        do_op(8'hFF, 8'hC8, 1'b0, 8'h00, 8, 0, "sat_200");
        do_op(8'h80, 8'd7, 1'b0, 8'h01, 7, 4, "backpressure");
        do_op(8'h90, 8'd2, 1'b1, SRA ? 8'hE4 : 8'h24, 2, 0, "arith_2");
        do_op(8'h90, 8'd12, 1'b1, SRA ? 8'hFF : 8'h00, 8, 0, "arith_sat");

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) == 0);
            a         = 8'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            arith     = 1'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
